// File: rtl/line_burst_master.sv
// Moves one cache line between a local line buffer and an Avalon-MM slave
// as a single fixed-length burst, as either a fill (read) or a write-back.
module line_burst_master #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rest,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_W-1:0]             cmd_address,
  output logic [$clog2(LINE_WORDS)-1:0] wbuf_index,
  input  logic [31:0]                   wbuf_data,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_index,
  output logic [31:0]                   fill_data,
  output logic                          done,
  output logic [ADDR_W-1:0]             m0_address,
  output logic [3:0]                    m0_byteEnable,
  output logic                          m0_read,
  output logic                          m0_write,
  output logic [31:0]                   m0_writeData,
  input  logic                          m0_waitRequest,
  input  logic [31:0]                   m0_readData,
  input  logic                          m0_readDataValid,
  output logic                          m0_beginBurstTransfer,
  output logic [7:0]                    m0_burstCount
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0]     LastBeat  = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {StIdle, StRdCmd, StRdData, StWrData, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_count;
  logic              r_first;
  logic              r_live;
  logic              r_fill_valid;
  logic [IW-1:0]     r_fill_index;
  logic [31:0]       r_fill_data;

  logic w_accept;
  logic w_rd_beat;
  logic w_wr_beat;
  logic w_busy;

  // r_live keeps cmd_ready low until the first clock after reset release.
  assign w_accept  = cmd_valid && r_live && (r_state == StIdle);
  assign w_rd_beat = m0_readDataValid && ((r_state == StRdCmd) || (r_state == StRdData));
  assign w_wr_beat = (r_state == StWrData) && !m0_waitRequest;

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    m0_read      = 1'b0;
    m0_write     = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        cmd_ready = r_live;
        if (w_accept) w_state_next = cmd_write ? StWrData : StRdCmd;
      end
      StRdCmd: begin
        m0_read = 1'b1;
        if (!m0_waitRequest) w_state_next = StRdData;
      end
      StRdData: begin
        if (w_rd_beat && (r_count == LastBeat)) w_state_next = StDone;
      end
      StWrData: begin
        m0_write = 1'b1;
        if (w_wr_beat && (r_count == LastBeat)) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_busy                = m0_read || m0_write;
  assign m0_byteEnable         = w_busy ? 4'hF : 4'h0;
  assign m0_burstCount         = w_busy ? 8'(LINE_WORDS) : 8'd0;
  assign m0_beginBurstTransfer = r_first && w_busy;
  assign m0_writeData          = m0_write ? wbuf_data : 32'd0;
  assign wbuf_index            = (r_state == StWrData) ? r_count[IW-1:0] : '0;
  assign m0_address            = r_addr;
  assign fill_valid            = r_fill_valid;
  assign fill_index            = r_fill_index;
  assign fill_data             = r_fill_data;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_addr       <= '0;
      r_count      <= '0;
      r_first      <= 1'b0;
      r_live       <= 1'b0;
      r_fill_valid <= 1'b0;
      r_fill_index <= '0;
      r_fill_data  <= '0;
    end else begin
      r_live       <= 1'b1;
      // Burst start flag lasts only the first cycle, so stalls never re-raise it.
      r_first      <= w_accept;
      r_fill_valid <= w_rd_beat;
      if (w_rd_beat) begin
        r_fill_data  <= m0_readData;
        r_fill_index <= r_count[IW-1:0];
      end
      if (w_accept) begin
        r_addr  <= cmd_address & AlignMask;
        r_count <= '0;
      end else if (w_rd_beat || w_wr_beat) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_burst_master.sv
// Scoreboard bench for line_burst_master: a negedge slave model drives the Avalon side,
// a monitor pops queued expectations whenever the DUT presents a fill or write beat.
module tb_line_burst_master;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_address = 32'd0;
  logic [2:0]  wbuf_index;
  logic [31:0] wbuf_data;
  logic        fill_valid;
  logic [2:0]  fill_index;
  logic [31:0] fill_data;
  logic        done;
  logic [31:0] m0_address;
  logic [3:0]  m0_byteEnable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writeData;
  logic        m0_waitRequest = 1'b0;
  logic [31:0] m0_readData = 32'd0;
  logic        m0_readDataValid = 1'b0;
  logic        m0_beginBurstTransfer;
  logic [7:0]  m0_burstCount;

  line_burst_master #(.LINE_WORDS(8), .ADDR_W(32)) u_dut (
    .clk                  (clk),
    .rest                 (rest),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_address          (cmd_address),
    .wbuf_index           (wbuf_index),
    .wbuf_data            (wbuf_data),
    .fill_valid           (fill_valid),
    .fill_index           (fill_index),
    .fill_data            (fill_data),
    .done                 (done),
    .m0_address           (m0_address),
    .m0_byteEnable        (m0_byteEnable),
    .m0_read              (m0_read),
    .m0_write             (m0_write),
    .m0_writeData         (m0_writeData),
    .m0_waitRequest       (m0_waitRequest),
    .m0_readData          (m0_readData),
    .m0_readDataValid     (m0_readDataValid),
    .m0_beginBurstTransfer(m0_beginBurstTransfer),
    .m0_burstCount        (m0_burstCount)
  );

  always #5 clk = ~clk;

  // Hand-computed squares of word indices 16..23 (address 0x40) and 32..39 (address 0x80).
  logic [31:0] sq16 [8] = '{32'h100, 32'h121, 32'h144, 32'h169,
                            32'h190, 32'h1B9, 32'h1E4, 32'h211};
  logic [31:0] sq32 [8] = '{32'h400, 32'h441, 32'h484, 32'h4C9,
                            32'h510, 32'h559, 32'h5A4, 32'h5F1};
  logic [31:0] wbuf_tab [8] = '{32'hCAFE0000, 32'h1234ABCD, 32'h0F0F0F0F, 32'hDEADBEEF,
                                32'h00000001, 32'h80000000, 32'h5A5AA5A5, 32'hFFFFFFFE};
  assign wbuf_data = wbuf_tab[wbuf_index];

  logic [31:0] mem [4096];
  beat_t       exp_fill [$];
  beat_t       exp_wr [$];
  logic [31:0] exp_addr = 32'd0;

  int n_chk = 0, n_pass = 0;
  int n_wr_cyc = 0, n_rd_cyc = 0, n_begin = 0, n_rd_acc = 0, n_fill = 0, n_done = 0;
  int n_wacc = 0;

  // Slave-model knobs and state.
  int          stall_a = 99, stall_b = 99, stall_len = 0, cmd_stall = 0;
  int          sl_beats = 0, sl_wait = 0, sl_cmd_wait = 0;
  int          rd_pending = 0, rd_idx = 0;
  logic [11:0] rd_base = 12'd0;
  logic        spurious = 1'b0;
  logic        wr_w;
  logic        prev_wr = 1'b0, prev_wait = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_wdata = 32'd0;
  logic [2:0]  prev_idx = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rd_pending > 0) begin
      m0_readDataValid = 1'b1;
      m0_readData      = mem[rd_base + 12'(rd_idx)];
      rd_idx++;
      rd_pending--;
    end else begin
      m0_readDataValid = spurious;
      m0_readData      = spurious ? 32'hDEADBEEF : 32'd0;
    end
    wr_w = 1'b0;
    if (m0_write) begin
      if (sl_wait < stall_len && (sl_beats == stall_a || sl_beats == stall_b)) begin
        wr_w = 1'b1;
        sl_wait++;
      end
    end else if (m0_read) begin
      if (sl_cmd_wait < cmd_stall) begin
        wr_w = 1'b1;
        sl_cmd_wait++;
      end
    end
    m0_waitRequest = wr_w;

    if (fill_valid) begin
      n_fill++;
      if (exp_fill.size() == 0) fail_now("fill_unexpected");
      else begin
        e = exp_fill.pop_front();
        check("fill_index", 32'(fill_index), 32'(e.idx));
        check("fill_data", fill_data, e.data);
      end
    end
    if (m0_write) n_wr_cyc++;
    if (m0_read) n_rd_cyc++;
    if (m0_beginBurstTransfer) begin
      n_begin++;
      check("m0_address", m0_address, exp_addr);
    end
    if (m0_write && prev_wr && prev_wait) begin
      check("stall_wdata", m0_writeData, prev_wdata);
      check("stall_windex", 32'(wbuf_index), 32'(prev_idx));
    end
    if (m0_write && !wr_w) begin
      mem[m0_address[13:2] + 12'(sl_beats)] = m0_writeData;
      n_wacc++;
      if (exp_wr.size() == 0) fail_now("wbeat_unexpected");
      else begin
        e = exp_wr.pop_front();
        check("wbuf_index", 32'(wbuf_index), 32'(e.idx));
        check("m0_writeData", m0_writeData, e.data);
      end
      sl_beats++;
      sl_wait = 0;
    end
    if (m0_read && !wr_w) begin
      rd_pending  = 8;
      rd_idx      = 0;
      rd_base     = m0_address[13:2];
      sl_cmd_wait = 0;
      n_rd_acc++;
    end
    if (!m0_write) begin
      sl_beats = 0;
      sl_wait  = 0;
    end
    if (!m0_read) sl_cmd_wait = 0;
    if (m0_read || m0_write) begin
      check("byteEnable", 32'(m0_byteEnable), 32'hF);
      check("burstCount", 32'(m0_burstCount), 32'd8);
    end else begin
      check("byteEnable_idle", 32'(m0_byteEnable), 32'h0);
      check("burstCount_idle", 32'(m0_burstCount), 32'h0);
    end
    if (done) begin
      n_done++;
      check("done_width", 32'(prev_done), 32'd0);
      check("done_after_fills", 32'(exp_fill.size()), 32'd0);
      check("ready_in_done", 32'(cmd_ready), 32'd0);
    end
    prev_wr    = m0_write;
    prev_wait  = wr_w;
    prev_wdata = m0_writeData;
    prev_idx   = wbuf_index;
    prev_done  = done;
  end

  task automatic push_read(input logic [31:0] t [8]);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.idx  = 3'(i);
      e.data = t[i];
      exp_fill.push_back(e);
    end
  endtask

  task automatic push_write();
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.idx  = 3'(i);
      e.data = wbuf_tab[i];
      exp_wr.push_back(e);
    end
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    exp_addr    = addr & ~32'h1F;
    cmd_write   = wr;
    cmd_address = addr;
    cmd_valid   = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (n_done == d0 && k < 300) begin
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    if (n_done == d0) fail_now("done_timeout");
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input bit hold);
    int d0 = n_done;
    start_cmd(wr, addr);
    if (!hold) cmd_valid = 1'b0;
    wait_done(d0);
  endtask

  initial begin
    int s_rd, s_wr, s_bg, s_acc, s_fill, s_done, s_wacc, k;
    for (int w = 0; w < 4096; w++) mem[w] = 32'(w * w);

    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_m0_read", 32'(m0_read), 32'd0);
    check("rst_m0_write", 32'(m0_write), 32'd0);
    check("rst_fill_valid", 32'(fill_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    rest = 1'b1;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Plain read of line 0x40.
    s_rd = n_rd_cyc; s_bg = n_begin; s_fill = n_fill; s_acc = n_rd_acc;
    push_read(sq16);
    do_cmd(1'b0, 32'h40, 1'b0);
    check("rd1_read_cycles", 32'(n_rd_cyc - s_rd), 32'd1);
    check("rd1_begin", 32'(n_begin - s_bg), 32'd1);
    check("rd1_fills", 32'(n_fill - s_fill), 32'd8);
    check("rd1_cmds", 32'(n_rd_acc - s_acc), 32'd1);
    tick();
    check("idle_gap_ready", 32'(cmd_ready), 32'd1);

    // Write-back of unaligned address 0x1234 -> 0x1220.
    s_wr = n_wr_cyc; s_bg = n_begin;
    push_write();
    do_cmd(1'b1, 32'h1234, 1'b0);
    check("wr1_write_cycles", 32'(n_wr_cyc - s_wr), 32'd8);
    check("wr1_begin", 32'(n_begin - s_bg), 32'd1);
    for (int i = 0; i < 8; i++) check("wr1_mem", mem[12'h488 + 12'(i)], wbuf_tab[i]);

    // Write with 3-cycle stalls on beats 0 and 5.
    stall_a = 0; stall_b = 5; stall_len = 3;
    s_wr = n_wr_cyc; s_bg = n_begin; s_wacc = n_wacc;
    push_write();
    do_cmd(1'b1, 32'h300, 1'b0);
    check("wr2_write_cycles", 32'(n_wr_cyc - s_wr), 32'd14);
    check("wr2_beats", 32'(n_wacc - s_wacc), 32'd8);
    check("wr2_begin", 32'(n_begin - s_bg), 32'd1);
    stall_a = 99; stall_b = 99; stall_len = 0;

    // Read with the command stalled 4 cycles.
    cmd_stall = 4;
    s_rd = n_rd_cyc; s_bg = n_begin; s_fill = n_fill;
    push_read(sq32);
    do_cmd(1'b0, 32'h80, 1'b0);
    check("rd2_read_cycles", 32'(n_rd_cyc - s_rd), 32'd5);
    check("rd2_begin", 32'(n_begin - s_bg), 32'd1);
    check("rd2_fills", 32'(n_fill - s_fill), 32'd8);
    cmd_stall = 0;

    // Reset after three accepted write beats.
    s_done = n_done;
    push_write();
    start_cmd(1'b1, 32'h200);
    cmd_valid = 1'b0;
    k = 0;
    while (sl_beats < 3 && k < 50) begin
      tick();
      k++;
    end
    if (sl_beats < 3) fail_now("reset_setup_timeout");
    @(posedge clk);
    #2;
    rest = 1'b0;
    #1;
    check("rstmid_m0_write", 32'(m0_write), 32'd0);
    check("rstmid_begin", 32'(m0_beginBurstTransfer), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd0);
    check("rstmid_addr", m0_address, 32'd0);
    exp_wr.delete();
    tick(); tick(); tick();
    rest = 1'b1;
    tick();
    check("rstmid_no_done", 32'(n_done - s_done), 32'd0);
    check("rstmid_ready_back", 32'(cmd_ready), 32'd1);
    s_fill = n_fill;
    push_read(sq32);
    do_cmd(1'b0, 32'h80, 1'b0);
    check("rstmid_read_fills", 32'(n_fill - s_fill), 32'd8);

    // Spurious readDataValid while idle, then cmd_valid held through a busy read.
    tick();
    s_fill = n_fill;
    spurious = 1'b1;
    tick(); tick(); tick();
    spurious = 1'b0;
    tick(); tick();
    check("spur_no_fill", 32'(n_fill - s_fill), 32'd0);
    s_acc = n_rd_acc; s_done = n_done;
    push_read(sq16);
    do_cmd(1'b0, 32'h40, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("busy_one_cmd", 32'(n_rd_acc - s_acc), 32'd1);
    check("busy_one_done", 32'(n_done - s_done), 32'd1);
    check("queues_empty", 32'(exp_fill.size() + exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
